// File: rtl/lb_cmd_pkg.sv
// Shared constants, state encoding and sizing helper for the byte-stream
// local bus command master.
package lb_cmd_pkg;

   localparam logic [7:0] OP_WR  = 8'h57;
   localparam logic [7:0] OP_RD  = 8'h52;

   localparam logic [7:0] RSP_K  = 8'h4B;
   localparam logic [7:0] RSP_D  = 8'h44;
   localparam logic [7:0] RSP_T  = 8'h54;
   localparam logic [7:0] RSP_E  = 8'h45;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ADDR,
      ST_GET_DATA,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_SEND_HDR,
      ST_SEND_DATA
   } state_t;

   // Number of whole bytes needed to carry a field of the given bit width.
   function automatic int byte_cnt(input int width_bits);
      return (width_bits + 7) / 8;
   endfunction

endpackage

// File: rtl/lb_cmd_rsp_ser.sv
// Response serializer: takes a header byte plus an optional data word and
// plays it out MSB first over the tx valid/ready handshake. done_o pulses
// on the handshake of the final byte.
module lb_cmd_rsp_ser
   import lb_cmd_pkg::*;
#(
   parameter int LB_DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [7:0]           hdr_i,
   input  logic                 pay_en_i,
   input  logic [LB_DATA_W-1:0] pay_i,
   input  logic                 tx_ready_i,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   output logic                 done_o
);

   localparam int NDB = byte_cnt(LB_DATA_W);
   localparam int CW  = $clog2(NDB + 1);

   logic                 valid_q;
   logic [7:0]           data_q;
   logic [LB_DATA_W-1:0] sh_q;
   logic [CW-1:0]        cnt_q;

   assign tx_valid_o = valid_q;
   assign tx_data_o  = data_q;
   assign done_o     = valid_q & tx_ready_i & (cnt_q == '0);

   // Load a new frame, or advance one byte on every accepted handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= hdr_i;
         sh_q    <= pay_i;
         cnt_q   <= pay_en_i ? CW'(NDB) : '0;
      end else if (valid_q && tx_ready_i) begin
         if (cnt_q != '0) begin
            data_q <= sh_q[LB_DATA_W-1 -: 8];
            sh_q   <= sh_q << 8;
            cnt_q  <= cnt_q - CW'(1);
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/lb_cmd_master.sv
// Byte-stream to local bus initiator. Parses W/R command frames, issues one
// strobed bus transaction at a time under a timeout, and answers with a
// K/D/T/E response frame.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   IDLE       | waiting for an opcode byte
//   GET_ADDR   | shifting in address bytes, MSB first
//   GET_DATA   | shifting in write data bytes, MSB first
//   ISSUE      | one-cycle lb_wr_en / lb_rd_en strobe
//   WAIT_RSP   | waiting for matching valid, counting toward timeout
//   SEND_HDR   | response header byte on tx
//   SEND_DATA  | read data bytes on tx
module lb_cmd_master
   import lb_cmd_pkg::*;
#(
   parameter int LB_DATA_W      = 32,
   parameter int LB_ADDR_W      = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic                 lb_wr_en,
   output logic                 lb_rd_en,
   output logic [LB_ADDR_W-1:0] lb_addr,
   output logic [LB_DATA_W-1:0] lb_wr_data,
   input  logic                 lb_wr_valid,
   input  logic                 lb_rd_valid,
   input  logic [LB_DATA_W-1:0] lb_rd_data,
   output logic                 busy
);

   localparam int NAB = byte_cnt(LB_ADDR_W);
   localparam int NDB = byte_cnt(LB_DATA_W);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

   state_t               state_q, state_d;
   logic                 is_wr_q, is_wr_d;
   logic [7:0]           bcnt_q, bcnt_d;
   logic [LB_ADDR_W-1:0] addr_q, addr_d;
   logic [LB_DATA_W-1:0] wdata_q, wdata_d;
   logic [TW-1:0]        tmo_q, tmo_d, tmo_inc;
   logic                 wr_en_q, rd_en_q, busy_q, rx_ready_q;

   logic                 rx_fire, rsp_hit;
   logic                 ser_load, ser_pay_en, ser_done;
   logic [7:0]           ser_hdr;

   assign rx_fire    = rx_valid & rx_ready_q;
   assign rsp_hit    = is_wr_q ? lb_wr_valid : lb_rd_valid;
   assign tmo_inc    = tmo_q + TW'(1);

   assign rx_ready   = rx_ready_q;
   assign busy       = busy_q;
   assign lb_wr_en   = wr_en_q;
   assign lb_rd_en   = rd_en_q;
   assign lb_addr    = addr_q;
   assign lb_wr_data = wdata_q;

   // Next-state, field shifting and response selection.
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      bcnt_d     = bcnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      tmo_d      = tmo_q;
      ser_load   = 1'b0;
      ser_hdr    = RSP_E;
      ser_pay_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_fire) begin
               if (rx_data == OP_WR || rx_data == OP_RD) begin
                  is_wr_d = (rx_data == OP_WR);
                  bcnt_d  = 8'(NAB - 1);
                  state_d = ST_GET_ADDR;
               end else begin
                  ser_load = 1'b1;
                  state_d  = ST_SEND_HDR;
               end
            end
         end
         ST_GET_ADDR: begin
            if (rx_fire) begin
               addr_d = LB_ADDR_W'({addr_q, rx_data});
               if (bcnt_q == '0) begin
                  if (is_wr_q) begin
                     bcnt_d  = 8'(NDB - 1);
                     state_d = ST_GET_DATA;
                  end else begin
                     state_d = ST_ISSUE;
                  end
               end else begin
                  bcnt_d = bcnt_q - 8'd1;
               end
            end
         end
         ST_GET_DATA: begin
            if (rx_fire) begin
               wdata_d = LB_DATA_W'({wdata_q, rx_data});
               if (bcnt_q == '0) begin
                  state_d = ST_ISSUE;
               end else begin
                  bcnt_d = bcnt_q - 8'd1;
               end
            end
         end
         ST_ISSUE, ST_WAIT_RSP: begin
            // A completion in the strobe cycle itself is honoured.
            tmo_d = (state_q == ST_ISSUE) ? '0 : tmo_inc;
            if (rsp_hit) begin
               ser_load   = 1'b1;
               ser_hdr    = is_wr_q ? RSP_K : RSP_D;
               ser_pay_en = ~is_wr_q;
               state_d    = ST_SEND_HDR;
            end else if (state_q == ST_ISSUE) begin
               state_d = ST_WAIT_RSP;
            end else if (tmo_inc == TMO_LAST) begin
               ser_load = 1'b1;
               ser_hdr  = RSP_T;
               state_d  = ST_SEND_HDR;
            end
         end
         ST_SEND_HDR: begin
            if (ser_done) begin
               state_d = ST_IDLE;
            end else if (tx_valid && tx_ready) begin
               state_d = ST_SEND_DATA;
            end
         end
         ST_SEND_DATA: begin
            if (ser_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers plus outputs registered from the upcoming state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         is_wr_q    <= 1'b0;
         bcnt_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         tmo_q      <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         rx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         bcnt_q     <= bcnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         wr_en_q    <= (state_d == ST_ISSUE) && is_wr_d;
         rd_en_q    <= (state_d == ST_ISSUE) && !is_wr_d;
         busy_q     <= (state_d != ST_IDLE);
         rx_ready_q <= (state_d inside {ST_IDLE, ST_GET_ADDR, ST_GET_DATA});
      end
   end

   lb_cmd_rsp_ser #(
      .LB_DATA_W (LB_DATA_W)
   ) u_rsp_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ser_load),
      .hdr_i      (ser_hdr),
      .pay_en_i   (ser_pay_en),
      .pay_i      (lb_rd_data),
      .tx_ready_i (tx_ready),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .done_o     (ser_done)
   );

endmodule

// File: tb/tb_lb_cmd_master.sv
// Bench for lb_cmd_master: directed and randomized command frames against a
// frame-level expectation of strobe timing, bus fields and response bytes.
module tb_lb_cmd_master;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        lb_wr_en, lb_rd_en;
   logic [15:0] lb_addr;
   logic [31:0] lb_wr_data;
   logic        lb_wr_valid = 1'b0;
   logic        lb_rd_valid = 1'b0;
   logic [31:0] lb_rd_data = 32'h0;
   logic        busy;

   lb_cmd_master #(.LB_DATA_W(32), .LB_ADDR_W(16), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr),
      .lb_wr_data(lb_wr_data), .lb_wr_valid(lb_wr_valid),
      .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Observed bus strobes and tx traffic, recorded per cycle.
   int          stb_cyc_q[$];
   bit          stb_wr_q[$];
   logic [15:0] stb_addr_q[$];
   logic [31:0] stb_data_q[$];
   logic [7:0]  tx_b_q[$];
   int          tx_c_q[$];
   int          rise_q[$];
   bit          chk_rx_low = 1'b0;
   bit          bp = 1'b0;
   logic        prev_txv = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_txd = 8'h00;

   task automatic clear_q();
      stb_cyc_q.delete(); stb_wr_q.delete(); stb_addr_q.delete(); stb_data_q.delete();
      tx_b_q.delete(); tx_c_q.delete(); rise_q.delete();
   endtask

   // Monitor: sample mid-cycle, log strobes/handshakes, check stall stability.
   always @(negedge clk) begin
      if (lb_wr_en || lb_rd_en) begin
         stb_cyc_q.push_back(cyc);
         stb_wr_q.push_back(lb_wr_en);
         stb_addr_q.push_back(lb_addr);
         stb_data_q.push_back(lb_wr_data);
         chk("strobe_exclusive", {1'b0, lb_wr_en & lb_rd_en}, 0);
         chk("busy_at_strobe", busy, 1);
      end
      if (tx_valid && tx_ready) begin
         tx_b_q.push_back(tx_data);
         tx_c_q.push_back(cyc);
      end
      if (tx_valid && !prev_txv) rise_q.push_back(cyc);
      if (prev_stall) begin
         chk("tx_hold_valid", tx_valid, 1);
         chk("tx_hold_data", tx_data, prev_txd);
      end
      if (chk_rx_low) chk("rx_ready_low", rx_ready, 0);
      prev_stall = tx_valid && !tx_ready;
      prev_txd   = tx_data;
      prev_txv   = tx_valid;
   end

   // Responder: pulses the matching valid rsp_delay cycles after the strobe.
   int          rsp_delay = -1;
   logic [31:0] rsp_data = 32'h0;
   bit          rsp_wrong = 1'b0;
   bit          inj_wr = 1'b0, inj_rd = 1'b0;
   initial begin
      int cd;
      bit pend, pwr;
      cd = 0; pend = 1'b0; pwr = 1'b0;
      forever begin
         @(posedge clk); #1;
         lb_wr_valid = inj_wr;
         lb_rd_valid = inj_rd;
         lb_rd_data  = $urandom;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if ((lb_wr_en || lb_rd_en) && rsp_delay >= 0) begin
               pend = 1'b1; cd = rsp_delay; pwr = lb_wr_en;
            end
            if (pend) begin
               if (cd == 0) begin
                  if (pwr) lb_wr_valid = 1'b1;
                  else begin lb_rd_valid = 1'b1; lb_rd_data = rsp_data; end
                  pend = 1'b0;
               end else begin
                  if (rsp_wrong && cd == 1) begin
                     if (pwr) lb_rd_valid = 1'b1; else lb_wr_valid = 1'b1;
                  end
                  cd--;
               end
            end
         end
      end
   end

   // Downstream tx acceptance, optionally random.
   initial forever begin
      @(posedge clk); #1;
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Called just after a rising edge; returns the cycle the byte was accepted.
   task automatic send_byte(input logic [7:0] b, output int acc);
      int g;
      bit done;
      g = 0; done = 1'b0; acc = -1;
      rx_valid = 1'b1; rx_data = b;
      while (!done) begin
         @(negedge clk);
         if (rx_ready) begin
            acc = cyc; done = 1'b1;
         end else begin
            g++;
            if (g > 1000) begin
               chk("rx_accept", rx_ready, 1);
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int g;
      g = 0;
      while (tx_b_q.size() < n && g < 3000) begin
         @(posedge clk); g++;
      end
      #1;
      chk_rx_low = 1'b0;
      if (g >= 3000) chk("tx_wait_bound", tx_b_q.size(), n);
   endtask

   // One command frame with its expected strobe and response.
   task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                          input int dly, input logic [31:0] rd, input bit wrong, input bit bp_on);
      logic [7:0] fr[$];
      logic [7:0] exp_b[$];
      int acc, s, exp_rise;
      bit tmo;
      clear_q();
      rsp_delay = dly; rsp_data = rd; rsp_wrong = wrong; bp = bp_on;
      fr.push_back(wr ? 8'h57 : 8'h52);
      fr.push_back(addr[15:8]); fr.push_back(addr[7:0]);
      if (wr) begin
         fr.push_back(wd[31:24]); fr.push_back(wd[23:16]);
         fr.push_back(wd[15:8]);  fr.push_back(wd[7:0]);
      end
      acc = 0;
      foreach (fr[i]) send_byte(fr[i], acc);
      chk_rx_low = 1'b1;
      s   = acc + 1;
      tmo = (dly < 0) || (dly > TMO);
      if (tmo) exp_b.push_back(8'h54);
      else if (wr) exp_b.push_back(8'h4B);
      else begin
         exp_b.push_back(8'h44);
         exp_b.push_back(rd[31:24]); exp_b.push_back(rd[23:16]);
         exp_b.push_back(rd[15:8]);  exp_b.push_back(rd[7:0]);
      end
      exp_rise = tmo ? s + TMO + 1 : s + dly + 1;
      wait_tx(exp_b.size());
      bp = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("tx_count", tx_b_q.size(), exp_b.size());
      chk("strobe_count", stb_cyc_q.size(), 1);
      if (stb_cyc_q.size() > 0) begin
         chk("strobe_cycle", stb_cyc_q[0], s);
         chk("strobe_kind", stb_wr_q[0], wr);
         chk("strobe_addr", stb_addr_q[0], addr);
         if (wr) chk("strobe_wdata", stb_data_q[0], wd);
      end
      chk("tx_rise_count", rise_q.size(), 1);
      if (rise_q.size() > 0) chk("rsp_latency", rise_q[0] - s, exp_rise - s);
      foreach (exp_b[i]) begin
         if (i < tx_b_q.size()) begin
            chk("tx_byte", tx_b_q[i], exp_b[i]);
            if (!bp_on && i > 0) chk("tx_back_to_back", tx_c_q[i] - tx_c_q[0], i);
         end
      end
      chk("lb_addr_hold", lb_addr, addr);
      chk("busy_idle", busy, 0);
   endtask

   task automatic bad_op(input logic [7:0] b);
      int acc;
      clear_q();
      send_byte(b, acc);
      wait_tx(1);
      repeat (3) @(posedge clk);
      #1;
      chk("err_tx_count", tx_b_q.size(), 1);
      if (tx_b_q.size() > 0) chk("err_byte", tx_b_q[0], 8'h45);
      if (rise_q.size() > 0) chk("err_latency", rise_q[0] - acc, 1);
      chk("err_no_strobe", stb_cyc_q.size(), 0);
   endtask

   task automatic check_zero();
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_wr_en", lb_wr_en, 0);
      chk("rst_rd_en", lb_rd_en, 0);
      chk("rst_addr", lb_addr, 0);
      chk("rst_wr_data", lb_wr_data, 0);
      chk("rst_busy", busy, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, dly;
      logic [7:0] bad[6];
      bad = '{8'h33, 8'h00, 8'hFF, 8'h56, 8'h53, 8'h77};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_txn(1'b1, 16'h0012, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 16'h0040, 32'h0, 2, 32'hCAFE0001, 1'b0, 1'b0);
      run_txn(1'b1, 16'($urandom), $urandom, 0, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 16'($urandom), 32'h0, 0, $urandom, 1'b0, 1'b0);

      // Timeout, then late completions that must be ignored.
      run_txn(1'b0, 16'($urandom), 32'h0, -1, 32'h0, 1'b0, 1'b0);
      clear_q();
      @(negedge clk); inj_rd = 1'b1; inj_wr = 1'b1;
      @(negedge clk); inj_rd = 1'b0; inj_wr = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("late_no_tx", tx_b_q.size(), 0);
      chk("late_no_strobe", stb_cyc_q.size(), 0);
      chk("late_busy", busy, 0);
      run_txn(1'b0, 16'($urandom), 32'h0, 4, $urandom, 1'b0, 1'b0);

      // Timeout window edges.
      run_txn(1'b0, 16'($urandom), 32'h0, TMO, $urandom, 1'b0, 1'b0);
      run_txn(1'b1, 16'($urandom), $urandom, TMO + 1, 32'h0, 1'b0, 1'b0);

      bad_op(8'h33);
      run_txn(1'b0, 16'h0040, 32'h0, 1, 32'hCAFE0001, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++)
         run_txn(1'b0, 16'($urandom), 32'h0, $urandom_range(0, 6), $urandom, 1'b0, 1'b1);

      run_txn(1'b1, 16'($urandom), $urandom, 5, 32'h0, 1'b1, 1'b0);
      run_txn(1'b0, 16'($urandom), 32'h0, 4, $urandom, 1'b1, 1'b0);

      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 5) == 0) bad_op(bad[$urandom_range(0, 5)]);
         dly = $urandom_range(0, 12);
         run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, dly, $urandom,
                 (dly >= 2) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
      end

      // Reset in the cycle after the second address byte of a write.
      clear_q();
      rsp_delay = 3; rsp_wrong = 1'b0;
      send_byte(8'h57, acc);
      send_byte(8'hAB, acc);
      send_byte(8'hCD, acc);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_zero();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_no_strobe", stb_cyc_q.size(), 0);
      chk("rst_no_tx", tx_b_q.size(), 0);
      run_txn(1'b1, 16'($urandom), $urandom, 2, 32'h0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
